// File: rtl/pong_pkg.sv
// pong_pkg: state codes, default match timing and screen constants shared with the pixel generator.
package pong_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4,
    S_PAUSE = 3'd5
  } state_e;
  localparam int DEF_WIN_SCORE    = 11;
  localparam int DEF_SCORE_W      = 4;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;
  localparam int DEF_CNT_W        = 8;
  localparam int H_RES            = 640;
  localparam int V_RES            = 480;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchroniser plus rising-edge pulse for a raw asynchronous button.
module btn_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic rise_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sh_q <= '0;
    else       sh_q <= {sh_q[1:0], btn_i};
  assign rise_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match sequencer (scores, serve/point timing, ball gating).
// Optional pause feature enabled by defining PONG_PAUSE_EN.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               refr_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               play_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic [2:0]         state_o,
  output logic               winner_valid,
  output logic               winner
);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_FRAMES);
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SCORE_W-1:0] left_q, right_q;
  logic play_en_q, ball_reset_q, serve_dir_q, winner_valid_q, winner_q;
  logic start_rise, pause_rise;
  btn_sync_edge u_start (.clk(clk), .rstn(rstn), .btn_i(start_btn), .rise_o(start_rise));
`ifdef PONG_PAUSE_EN
  btn_sync_edge u_pause (.clk(clk), .rstn(rstn), .btn_i(pause_btn), .rise_o(pause_rise));
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign pause_rise   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      left_q         <= '0;
      right_q        <= '0;
      play_en_q      <= 1'b0;
      ball_reset_q   <= 1'b1;
      serve_dir_q    <= 1'b1;
      winner_valid_q <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER:
          if (start_rise) begin
            state_q        <= S_SERVE;
            left_q         <= '0;
            right_q        <= '0;
            serve_dir_q    <= 1'b1;
            cnt_q          <= SERVE_LD;
            winner_valid_q <= 1'b0;
          end
        S_SERVE:
          if (refr_tick) begin
            if (cnt_q == '0) begin
              state_q      <= S_PLAY;
              play_en_q    <= 1'b1;
              ball_reset_q <= 1'b0;
            end else cnt_q <= cnt_q - 1'b1;
          end
        S_PLAY:
          if (miss_left || miss_right) begin
            state_q      <= S_POINT;
            play_en_q    <= 1'b0;
            ball_reset_q <= 1'b1;
            cnt_q        <= POINT_LD;
            // a simultaneous double miss is a replay: no score, serve side kept
            if (miss_left && !miss_right) begin
              right_q     <= (right_q == WIN) ? right_q : right_q + 1'b1;
              serve_dir_q <= 1'b0;
            end
            if (miss_right && !miss_left) begin
              left_q      <= (left_q == WIN) ? left_q : left_q + 1'b1;
              serve_dir_q <= 1'b1;
            end
          end else if (pause_rise) begin
            state_q   <= S_PAUSE;
            play_en_q <= 1'b0;
          end
        S_POINT:
          if (refr_tick) begin
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            else if (left_q == WIN || right_q == WIN) begin
              state_q        <= S_OVER;
              winner_valid_q <= 1'b1;
              winner_q       <= (right_q == WIN);
            end else begin
              state_q <= S_SERVE;
              cnt_q   <= SERVE_LD;
            end
          end
        S_PAUSE:
          if (pause_rise) begin
            state_q   <= S_PLAY;
            play_en_q <= 1'b1;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  assign play_en      = play_en_q;
  assign ball_reset   = ball_reset_q;
  assign serve_dir    = serve_dir_q;
  assign left_score   = left_q;
  assign right_score  = right_q;
  assign state_o      = state_q;
  assign winner_valid = winner_valid_q;
  assign winner       = winner_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: scoreboard bench for the match sequencer with shortened timing.
module tb_pong_match_ctrl;
  localparam int WS = 3;
  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4, PAUSE = 3'd5;
  logic clk = 1'b0, rstn = 1'b0, refr_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic miss_left = 1'b0, miss_right = 1'b0;
  logic play_en, ball_reset, serve_dir, winner_valid, winner;
  logic [3:0] left_score, right_score;
  logic [2:0] state_o;
  int total = 0, bad = 0;
  typedef struct {
    logic [2:0] st;
    logic pe, br, sd, wv, w;
    logic [3:0] ls, rs;
  } snap_t;
  snap_t exp_q[$];
  logic [2:0] m_st;
  logic [3:0] m_ls, m_rs;
  logic m_sd, m_wv, m_w;
  pong_match_ctrl #(.WIN_SCORE(WS), .SCORE_W(4), .SERVE_FRAMES(3), .POINT_FRAMES(2), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .refr_tick(refr_tick), .start_btn(start_btn), .pause_btn(pause_btn),
    .miss_left(miss_left), .miss_right(miss_right), .play_en(play_en), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .left_score(left_score), .right_score(right_score), .state_o(state_o),
    .winner_valid(winner_valid), .winner(winner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask
  task automatic push_exp();
    snap_t s;
    s.st = m_st;
    s.pe = (m_st == PLAY);
    s.br = !(m_st == PLAY || m_st == PAUSE);
    s.sd = m_sd;
    s.ls = m_ls;
    s.rs = m_rs;
    s.wv = m_wv;
    s.w  = m_w;
    exp_q.push_back(s);
  endtask
  task automatic compare();
    snap_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("state", 8'(state_o), 8'(e.st));
    chk("play_en", 8'(play_en), 8'(e.pe));
    chk("ball_reset", 8'(ball_reset), 8'(e.br));
    chk("serve_dir", 8'(serve_dir), 8'(e.sd));
    chk("left_score", 8'(left_score), 8'(e.ls));
    chk("right_score", 8'(right_score), 8'(e.rs));
    chk("winner_valid", 8'(winner_valid), 8'(e.wv));
    if (e.wv || e.st == IDLE) chk("winner", 8'(winner), 8'(e.w));
  endtask
  task automatic observe();
    push_exp();
    compare();
  endtask
  task automatic model_reset();
    m_st = IDLE; m_ls = 0; m_rs = 0; m_sd = 1'b1; m_wv = 1'b0; m_w = 1'b0;
  endtask
  task automatic frame();
    refr_tick = 1'b1;
    @(negedge clk);
    refr_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic press_start();
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    observe();
    @(negedge clk);
    if (m_st == IDLE || m_st == OVER) begin
      m_st = SERVE; m_ls = 0; m_rs = 0; m_sd = 1'b1; m_wv = 1'b0;
    end
    observe();
    start_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic serve_to_play();
    repeat (3) begin
      frame();
      observe();
    end
    frame();
    m_st = PLAY;
    observe();
  endtask
  task automatic miss(input logic ml, input logic mr);
    miss_left = ml;
    miss_right = mr;
    @(negedge clk);
    miss_left = 1'b0;
    miss_right = 1'b0;
  endtask
  task automatic point(input logic ml, input logic mr);
    miss(ml, mr);
    m_st = POINT;
    if (ml && !mr) begin m_rs++; m_sd = 1'b0; end
    if (mr && !ml) begin m_ls++; m_sd = 1'b1; end
    observe();
    repeat (2) begin
      frame();
      observe();
    end
    frame();
    if (m_ls == WS || m_rs == WS) begin
      m_st = OVER; m_wv = 1'b1; m_w = (m_rs == WS);
    end else m_st = SERVE;
    observe();
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    observe();
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      frame();
      observe();
    end
    press_start();
    miss(1'b1, 1'b0);
    observe();
    press_start();
    serve_to_play();
    point(1'b1, 1'b0);
    serve_to_play();
    point(1'b1, 1'b1);
    serve_to_play();
    point(1'b0, 1'b1);
    serve_to_play();
    point(1'b0, 1'b1);
    serve_to_play();
    point(1'b0, 1'b1);
    miss(1'b1, 1'b0);
    frame();
    observe();
    press_start();
    serve_to_play();
`ifdef PONG_PAUSE_EN
    pause_btn = 1'b1;
    repeat (2) @(negedge clk);
    observe();
    @(negedge clk);
    m_st = PAUSE;
    observe();
    miss(1'b1, 1'b0);
    frame();
    observe();
    pause_btn = 1'b0;
    repeat (3) @(negedge clk);
    pause_btn = 1'b1;
    repeat (3) @(negedge clk);
    m_st = PLAY;
    observe();
    pause_btn = 1'b0;
    repeat (3) @(negedge clk);
`endif
    repeat (3) begin
      point(1'b1, 1'b0);
      if (m_st == SERVE) serve_to_play();
    end
    press_start();
    serve_to_play();
    #2 rstn = 1'b0;
    #1 model_reset();
    observe();
    @(negedge clk);
    rstn = 1'b1;
    frame();
    observe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
